// File: rtl/pmv_update_engine.sv
// pmv_update_engine
//   Motion-vector predictor update engine. One sweep walks the NUM_ENT = 2*NUM_VEC
//   PMV components (even entry = horizontal, odd entry = vertical, entry>>1 = vector).
//   Each component is read from the PMV/delta RAMs, gets its decoded delta added, is
//   wrapped into the f_code range and is written back. The sweep handles one entry
//   per cycle.
//
// Ports
//   clock, resetn      rising-edge clock, synchronous active-low reset
//   start_i            begin a sweep (sampled only while idle)
//   pmv_clear_i        latched at start: use 0 as the predictor for every entry
//   field_i            latched at start: field-mode vertical scaling
//   vec_mask_i         latched at start: bit v set -> vector v is updated
//   f_codes_i          {f[0][0],f[0][1],f[1][0],f[1][1]}, read live during the sweep
//   rd_index_o         read address for the delta RAM and the PMV RAM
//   delta_i, pmv_i     RAM read data, one cycle after rd_index_o
//   wr_index_o, wr_data_o, wr_en_o   PMV RAM write port
//   busy_o             high whenever the engine is not idle
//   done_o             one-cycle pulse at the end of a sweep
//   err_o              sticky invalid-f_code flag, cleared by the next accepted start
//   dbg_state_o        current FSM state (0 idle, 1 run, 2 done)
//
// Handshake: start_i is a request that is accepted on any clock edge where the engine
// is idle (busy_o low); there is no acknowledge beyond busy_o rising in the following
// cycle. Requests while busy are dropped. done_o pulses in the last busy cycle, and a
// new request can be accepted in the cycle right after it.
module pmv_update_engine #(
    parameter int NUM_VEC = 4,
    parameter int MV_W    = 16,
    parameter int DELTA_W = 13,
    parameter int IDX_W   = 3
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start_i,
    input  logic               pmv_clear_i,
    input  logic               field_i,
    input  logic [NUM_VEC-1:0] vec_mask_i,
    input  logic [15:0]        f_codes_i,
    output logic [IDX_W-1:0]   rd_index_o,
    input  logic [DELTA_W:0]   delta_i,
    input  logic [MV_W-1:0]    pmv_i,
    output logic [IDX_W-1:0]   wr_index_o,
    output logic [MV_W-1:0]    wr_data_o,
    output logic               wr_en_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [1:0]         dbg_state_o
);

    localparam int NUM_ENT = 2 * NUM_VEC;
    localparam int CW      = IDX_W + 1;    // counter must reach NUM_ENT
    localparam int AW      = MV_W + 2;     // arithmetic width

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic               clear_q, field_q, err_q;
    logic [NUM_VEC-1:0] mask_q;

    logic               start_acc;
    logic               proc_valid, upd, f_bad, err_set, scale;
    logic [CW-1:0]      ent_full;
    logic [IDX_W-1:0]   ent;
    logic               sel_s, sel_t;
    logic [3:0]         f_sel, shamt;

    logic signed [AW-1:0] base, pred, mag, delta_s;
    logic signed [AW-1:0] half, span, high, low, sum, sum_wrap, result;
    logic                 unused_bits;

    assign start_acc = (state_q == S_IDLE) && start_i;

    // ---------------- state register and captured controls ----------------
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            clear_q <= 1'b0;
            field_q <= 1'b0;
            mask_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                cnt_q   <= '0;
                clear_q <= pmv_clear_i;
                field_q <= field_i;
                mask_q  <= vec_mask_i;
                err_q   <= 1'b0;
            end else begin
                if (state_q == S_RUN) begin
                    cnt_q <= cnt_q + CW'(1);
                end
                if (err_set) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (cnt_q == CW'(NUM_ENT)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Cycle c of the run reads entry c and processes entry c-1, whose RAM data
    // arrived this cycle. Cycle 0 only primes the read.
    assign proc_valid = (state_q == S_RUN) && (cnt_q != '0);
    assign ent_full   = cnt_q - CW'(1);
    assign ent        = ent_full[IDX_W-1:0];
    assign sel_t      = ent[0];
    assign sel_s      = (ent >= IDX_W'(NUM_VEC));
    assign upd        = proc_valid && mask_q[ent[IDX_W-1:1]];
    assign scale      = field_q && sel_t;

    always_comb begin
        f_sel = 4'd0;
        case ({sel_s, sel_t})
            2'b00:   f_sel = f_codes_i[15:12];
            2'b01:   f_sel = f_codes_i[11:8];
            2'b10:   f_sel = f_codes_i[7:4];
            default: f_sel = f_codes_i[3:0];
        endcase
    end

    assign f_bad   = (f_sel == 4'd0) || (f_sel > 4'd9);
    assign err_set = upd && f_bad;

    // ---------------- wrap arithmetic ----------------
    // With a legal delta the sum is at most one range outside [low, high], so a
    // single add/subtract of the range is enough. For an invalid f_code the shift
    // amount is meaningless, but the result is not used then.
    always_comb begin
        base     = clear_q ? '0 : AW'($signed(pmv_i));
        pred     = scale ? (base >>> 1) : base;
        mag      = AW'(delta_i[DELTA_W-1:0]);
        delta_s  = delta_i[DELTA_W] ? -mag : mag;
        shamt    = f_sel - 4'd1;
        half     = AW'(16) << shamt;
        span     = half << 1;
        high     = half - AW'(1);
        low      = -half;
        sum      = pred + delta_s;
        sum_wrap = sum;
        if (sum > high) begin
            sum_wrap = sum - span;
        end else if (sum < low) begin
            sum_wrap = sum + span;
        end
        result   = scale ? (sum_wrap <<< 1) : sum_wrap;
    end

    // ---------------- outputs ----------------
    always_comb begin
        rd_index_o = '0;
        if ((state_q == S_RUN) && (cnt_q < CW'(NUM_ENT))) begin
            rd_index_o = cnt_q[IDX_W-1:0];
        end
        wr_index_o = proc_valid ? ent : '0;
        wr_en_o    = upd;
        wr_data_o  = '0;
        if (upd) begin
            // An invalid f_code leaves the predictor as it was.
            wr_data_o = f_bad ? base[MV_W-1:0] : result[MV_W-1:0];
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

    assign unused_bits = ^{ent_full[CW-1], result[AW-1:MV_W]};

endmodule

// File: tb/tb_pmv_update_engine.sv
module tb_pmv_update_engine;

    localparam int NUM_VEC = 4;
    localparam int MV_W    = 16;
    localparam int DELTA_W = 13;
    localparam int IDX_W   = 3;
    localparam int NUM_ENT = 2 * NUM_VEC;
    localparam int WIN     = NUM_ENT + 5;

    // ---------------- clock / reset / DUT ----------------
    logic               clock       = 1'b0;
    logic               resetn      = 1'b0;
    logic               start_i     = 1'b0;
    logic               pmv_clear_i = 1'b0;
    logic               field_i     = 1'b0;
    logic [NUM_VEC-1:0] vec_mask_i  = '0;
    logic [15:0]        f_codes_i   = '0;
    logic [IDX_W-1:0]   rd_index_o, wr_index_o;
    logic [DELTA_W:0]   delta_i;
    logic [MV_W-1:0]    pmv_i, wr_data_o;
    logic               wr_en_o, busy_o, done_o, err_o;
    logic [1:0]         dbg_state_o;

    always #5 clock = ~clock;

    pmv_update_engine #(
        .NUM_VEC(NUM_VEC), .MV_W(MV_W), .DELTA_W(DELTA_W), .IDX_W(IDX_W)
    ) dut (
        .clock(clock), .resetn(resetn), .start_i(start_i),
        .pmv_clear_i(pmv_clear_i), .field_i(field_i), .vec_mask_i(vec_mask_i),
        .f_codes_i(f_codes_i), .rd_index_o(rd_index_o), .delta_i(delta_i),
        .pmv_i(pmv_i), .wr_index_o(wr_index_o), .wr_data_o(wr_data_o),
        .wr_en_o(wr_en_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .dbg_state_o(dbg_state_o)
    );

    // Synchronous-read RAMs feeding the engine.
    logic [MV_W-1:0]  pmv_mem[NUM_ENT];
    logic [DELTA_W:0] delta_mem[NUM_ENT];

    always @(posedge clock) begin
        pmv_i   <= pmv_mem[rd_index_o];
        delta_i <= delta_mem[rd_index_o];
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    logic [MV_W-1:0] exp_q[$];
    int              exp_idx[$];
    bit              exp_err;

    int              wr_rel[$];
    int              wr_idx[$];
    logic [MV_W-1:0] wr_dat[$];
    int              done_rel[$];
    bit              busy_at[WIN];

    // ---------------- helpers ----------------
    function automatic logic [15:0] pack_f(input logic [3:0] f00, input logic [3:0] f01,
                                           input logic [3:0] f10, input logic [3:0] f11);
        return {f00, f01, f10, f11};
    endfunction

    function automatic void set_entry(input int e, input int pmv, input int d);
        logic [31:0] pv;
        logic [31:0] mv;
        pv = pmv;
        mv = (d < 0) ? -d : d;
        pmv_mem[e]   = pv[MV_W-1:0];
        delta_mem[e] = {(d < 0), mv[DELTA_W-1:0]};
    endfunction

    // Reference model of one entry, straight from the arithmetic rules.
    task automatic model_entry(input int e, input bit clear, input bit field,
                               input logic [15:0] fc, output logic [MV_W-1:0] val,
                               output bit bad);
        int s, t, f, pred, d, half, sum;
        logic [31:0] sum_bits;
        s    = (e >= NUM_VEC) ? 1 : 0;
        t    = e % 2;
        f    = int'((fc >> (4 * (3 - (2 * s + t)))) & 16'hF);
        d    = int'(delta_mem[e][DELTA_W-1:0]);
        if (delta_mem[e][DELTA_W]) d = -d;
        pred = clear ? 0 : int'($signed(pmv_mem[e]));
        bad  = (f < 1) || (f > 9);
        if (bad) begin
            sum = pred;
        end else begin
            if (field && t == 1) pred = pred >>> 1;
            half = 16 << (f - 1);
            sum  = pred + d;
            if (sum > half - 1)   sum = sum - 2 * half;
            else if (sum < -half) sum = sum + 2 * half;
            if (field && t == 1)  sum = sum * 2;
        end
        sum_bits = sum;
        val      = sum_bits[MV_W-1:0];
    endtask

    task automatic model_sweep(input bit clear, input bit field, input logic [3:0] mask,
                               input logic [15:0] fc);
        logic [MV_W-1:0] v;
        bit bad;
        exp_q.delete();
        exp_idx.delete();
        exp_err = 1'b0;
        for (int e = 0; e < NUM_ENT; e++) begin
            if (mask[e / 2]) begin
                model_entry(e, clear, field, fc, v, bad);
                exp_q.push_back(v);
                exp_idx.push_back(e);
                if (bad) exp_err = 1'b1;
            end
        end
    endtask

    task automatic set_ctrl(input bit clear, input bit field, input logic [3:0] mask,
                            input logic [15:0] fc);
        pmv_clear_i = clear;
        field_i     = field;
        vec_mask_i  = mask;
        f_codes_i   = fc;
    endtask

    // Starts a sweep (accept edge = T) and records what happens for a fixed window.
    // Relative times are edges after T at which the RAM captures a write.
    // hold keeps start_i high through the sweep; chain also keeps it high into the
    // first idle cycle so a second sweep starts back to back.
    task automatic run_sweep(input bit hold, input bit chain);
        wr_rel.delete();
        wr_idx.delete();
        wr_dat.delete();
        done_rel.delete();
        start_i = 1'b1;
        @(posedge clock);
        #1;
        if (!hold) start_i = 1'b0;
        for (int k = 0; k < WIN; k++) begin
            @(negedge clock);
            if (k == NUM_ENT + 2) start_i = chain;
            if (k == NUM_ENT + 3) start_i = 1'b0;
            busy_at[k] = busy_o;
            if (wr_en_o) begin
                wr_rel.push_back(k + 1);
                wr_idx.push_back(int'(wr_index_o));
                wr_dat.push_back(wr_data_o);
            end
            if (done_o) done_rel.push_back(k + 1);
        end
    endtask

    task automatic random_entries(input logic [15:0] fc);
        int f, half, m;
        for (int e = 0; e < NUM_ENT; e++) begin
            f = int'((fc >> (4 * (3 - (2 * ((e >= NUM_VEC) ? 1 : 0) + e % 2)))) & 16'hF);
            half = (f >= 1 && f <= 9) ? (16 << (f - 1)) : 256;
            m = int'($urandom_range(0, half));
            if ($urandom_range(0, 1) == 1) m = -m;
            set_entry(e, int'($urandom_range(0, 2 * half - 1)) - half, m);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        start_i = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
        checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en_o); end
        checks++; if (wr_data_o !== 16'h0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", wr_data_o); end
        checks++; if (wr_index_o !== 3'd0) begin errors++; $display("FAIL reset_wr_index: got %0d want 0", wr_index_o); end
        checks++; if (rd_index_o !== 3'd0) begin errors++; $display("FAIL reset_rd_index: got %0d want 0", rd_index_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
        start_i = 1'b0;
        resetn = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_basic();
        logic [15:0] fc;
        fc = pack_f(4'd1, 4'd1, 4'd1, 4'd1);
        for (int e = 0; e < NUM_ENT; e++) set_entry(e, 5, 3);
        set_ctrl(1'b0, 1'b0, 4'hF, fc);
        model_sweep(1'b0, 1'b0, 4'hF, fc);
        run_sweep(1'b0, 1'b0);
        checks++;
        if (wr_dat.size() !== NUM_ENT) begin
            errors++; $display("FAIL basic_count: got %0d writes want %0d", wr_dat.size(), NUM_ENT);
        end
        for (int i = 0; i < wr_dat.size() && i < NUM_ENT; i++) begin
            checks++;
            if (wr_idx[i] !== i || wr_dat[i] !== 16'd8 || wr_dat[i] !== exp_q[i] || wr_rel[i] !== i + 2) begin
                errors++;
                $display("FAIL basic_write[%0d]: got idx %0d data %h at T+%0d, want idx %0d data 0008 at T+%0d",
                         i, wr_idx[i], wr_dat[i], wr_rel[i], i, i + 2);
            end
        end
        checks++;
        if (done_rel.size() !== 1 || (done_rel.size() == 1 && done_rel[0] !== NUM_ENT + 2)) begin
            errors++; $display("FAIL basic_done: got %0d pulses first at T+%0d want 1 at T+%0d",
                               done_rel.size(), (done_rel.size() > 0) ? done_rel[0] : -1, NUM_ENT + 2);
        end
        for (int k = 0; k < WIN; k++) begin
            checks++;
            if (busy_at[k] !== (k <= NUM_ENT + 1)) begin
                errors++; $display("FAIL basic_busy[%0d]: got %b want %b", k, busy_at[k], (k <= NUM_ENT + 1));
            end
        end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", err_o); end
    endtask

    task automatic test_wrap();
        logic [15:0] fc;
        fc = pack_f(4'd1, 4'd2, 4'd9, 4'd3);
        set_entry(0, 14, 4);
        set_entry(1, -30, -5);
        set_entry(2, 3, -2);
        set_entry(3, 10, 7);
        set_entry(4, 4000, 200);
        set_entry(5, 60, 10);
        set_entry(6, -4000, -300);
        set_entry(7, -1, -1);
        set_ctrl(1'b0, 1'b0, 4'hF, fc);
        model_sweep(1'b0, 1'b0, 4'hF, fc);
        run_sweep(1'b0, 1'b0);
        checks++;
        if (wr_dat.size() !== NUM_ENT) begin
            errors++; $display("FAIL wrap_count: got %0d writes want %0d", wr_dat.size(), NUM_ENT);
        end else begin
            checks++; if (wr_dat[0] !== 16'hFFF2) begin errors++; $display("FAIL wrap_f1_high: got %h want fff2", wr_dat[0]); end
            checks++; if (wr_dat[1] !== 16'd29) begin errors++; $display("FAIL wrap_f2_low: got %h want 001d", wr_dat[1]); end
            checks++; if (wr_dat[4] !== 16'hF068) begin errors++; $display("FAIL wrap_f9_high: got %h want f068", wr_dat[4]); end
            for (int i = 0; i < NUM_ENT; i++) begin
                checks++;
                if (wr_idx[i] !== exp_idx[i] || wr_dat[i] !== exp_q[i]) begin
                    errors++; $display("FAIL wrap_model[%0d]: got idx %0d data %h want idx %0d data %h",
                                       i, wr_idx[i], wr_dat[i], exp_idx[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_field();
        logic [15:0] fc;
        fc = pack_f(4'd1, 4'd1, 4'd1, 4'd1);
        set_entry(0, 3, 2);
        set_entry(1, -7, 2);
        set_entry(2, -10, -3);
        set_entry(3, 20, -1);
        set_entry(4, 15, 5);
        set_entry(5, -31, -1);
        set_entry(6, 0, 0);
        set_entry(7, 9, 9);
        set_ctrl(1'b0, 1'b1, 4'hF, fc);
        model_sweep(1'b0, 1'b1, 4'hF, fc);
        run_sweep(1'b0, 1'b0);
        checks++;
        if (wr_dat.size() !== NUM_ENT) begin
            errors++; $display("FAIL field_count: got %0d writes want %0d", wr_dat.size(), NUM_ENT);
        end else begin
            checks++; if (wr_dat[0] !== 16'd5) begin errors++; $display("FAIL field_horiz: got %h want 0005", wr_dat[0]); end
            checks++; if (wr_dat[1] !== 16'hFFFC) begin errors++; $display("FAIL field_vert: got %h want fffc", wr_dat[1]); end
            for (int i = 0; i < NUM_ENT; i++) begin
                checks++;
                if (wr_dat[i] !== exp_q[i]) begin
                    errors++; $display("FAIL field_model[%0d]: got %h want %h", i, wr_dat[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_mask_err();
        logic [15:0] fc;
        int          want_idx[4];
        logic [15:0] want_dat[4];
        fc = pack_f(4'd1, 4'd1, 4'd1, 4'd0);
        for (int e = 0; e < NUM_ENT; e++) set_entry(e, 1234, 1);
        set_entry(0, 1234, 7);
        set_entry(1, 1234, -9);
        set_entry(4, 1234, 15);
        set_entry(5, 1234, 3);
        want_idx = '{0, 1, 4, 5};
        want_dat = '{16'h0007, 16'hFFF7, 16'h000F, 16'h0000};
        set_ctrl(1'b1, 1'b0, 4'b0101, fc);
        run_sweep(1'b0, 1'b0);
        checks++;
        if (wr_dat.size() !== 4) begin
            errors++; $display("FAIL mask_count: got %0d writes want 4", wr_dat.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_idx[i] !== want_idx[i] || wr_dat[i] !== want_dat[i] || wr_rel[i] !== want_idx[i] + 2) begin
                    errors++; $display("FAIL mask_write[%0d]: got idx %0d data %h at T+%0d want idx %0d data %h at T+%0d",
                                       i, wr_idx[i], wr_dat[i], wr_rel[i], want_idx[i], want_dat[i], want_idx[i] + 2);
                end
            end
        end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL mask_err_set: got %b want 1", err_o); end
        repeat (3) @(negedge clock);
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err_o); end
    endtask

    task automatic test_masked_invalid();
        logic [15:0] fc;
        fc = pack_f(4'd1, 4'd1, 4'd0, 4'd0);
        random_entries(fc);
        set_ctrl(1'b0, 1'b0, 4'b0011, fc);
        model_sweep(1'b0, 1'b0, 4'b0011, fc);
        run_sweep(1'b0, 1'b0);
        checks++;
        if (wr_dat.size() !== 4) begin
            errors++; $display("FAIL minv_count: got %0d writes want 4", wr_dat.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_idx[i] !== exp_idx[i] || wr_dat[i] !== exp_q[i]) begin
                    errors++; $display("FAIL minv_write[%0d]: got idx %0d data %h want idx %0d data %h",
                                       i, wr_idx[i], wr_dat[i], exp_idx[i], exp_q[i]);
                end
            end
        end
        // Also shows the earlier sticky error was cleared by this start.
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL minv_err: got %b want 0", err_o); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] fc;
        int          n_done;
        fc = pack_f(4'd3, 4'd4, 4'd5, 4'd6);
        random_entries(fc);
        set_ctrl(1'b0, 1'b0, 4'hF, fc);
        model_sweep(1'b0, 1'b0, 4'hF, fc);
        run_sweep(1'b1, 1'b1);
        checks++;
        if (done_rel.size() !== 1 || (done_rel.size() == 1 && done_rel[0] !== NUM_ENT + 2)) begin
            errors++; $display("FAIL b2b_single_done: got %0d pulses want 1 at T+%0d", done_rel.size(), NUM_ENT + 2);
        end
        checks++;
        if (wr_dat.size() !== NUM_ENT + 1) begin
            errors++; $display("FAIL b2b_count: got %0d writes want %0d", wr_dat.size(), NUM_ENT + 1);
        end else begin
            for (int i = 0; i < NUM_ENT; i++) begin
                checks++;
                if (wr_dat[i] !== exp_q[i] || wr_rel[i] !== i + 2) begin
                    errors++; $display("FAIL b2b_write[%0d]: got %h at T+%0d want %h at T+%0d",
                                       i, wr_dat[i], wr_rel[i], exp_q[i], i + 2);
                end
            end
            checks++;
            if (wr_rel[NUM_ENT] !== NUM_ENT + 5 || wr_dat[NUM_ENT] !== exp_q[0]) begin
                errors++; $display("FAIL b2b_second_start: got %h at T+%0d want %h at T+%0d",
                                   wr_dat[NUM_ENT], wr_rel[NUM_ENT], exp_q[0], NUM_ENT + 5);
            end
        end
        checks++;
        if (busy_at[NUM_ENT + 2] !== 1'b0 || busy_at[NUM_ENT + 3] !== 1'b1) begin
            errors++; $display("FAIL b2b_busy_gap: got %b%b want 01", busy_at[NUM_ENT + 2], busy_at[NUM_ENT + 3]);
        end
        n_done = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            if (done_o) n_done++;
        end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL b2b_second_done: got %0d pulses want 1", n_done); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy %b want 0", busy_o); end
    endtask

    task automatic test_random();
        logic [15:0] fc;
        logic [3:0]  fv[4];
        logic [3:0]  mask;
        bit          clear, field;
        for (int n = 0; n < 24; n++) begin
            clear = ($urandom_range(0, 3) == 0);
            field = ($urandom_range(0, 1) == 1);
            mask  = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) begin
                if (!field && $urandom_range(0, 7) == 0) fv[k] = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(10, 15));
                else fv[k] = 4'($urandom_range(1, 9));
            end
            fc = pack_f(fv[0], fv[1], fv[2], fv[3]);
            random_entries(fc);
            set_ctrl(clear, field, mask, fc);
            model_sweep(clear, field, mask, fc);
            run_sweep(1'b0, 1'b0);
            checks++;
            if (wr_dat.size() !== exp_q.size()) begin
                errors++; $display("FAIL rand%0d_count: got %0d writes want %0d", n, wr_dat.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (wr_idx[i] !== exp_idx[i] || wr_dat[i] !== exp_q[i] || wr_rel[i] !== exp_idx[i] + 2) begin
                        errors++; $display("FAIL rand%0d_write[%0d]: got idx %0d data %h at T+%0d want idx %0d data %h at T+%0d",
                                           n, i, wr_idx[i], wr_dat[i], wr_rel[i], exp_idx[i], exp_q[i], exp_idx[i] + 2);
                    end
                end
            end
            checks++; if (err_o !== exp_err) begin errors++; $display("FAIL rand%0d_err: got %b want %b", n, err_o, exp_err); end
        end
    endtask

    task automatic test_reset_mid();
        int bad_cnt;
        logic [15:0] fc;
        fc = pack_f(4'd2, 4'd2, 4'd2, 4'd2);
        random_entries(fc);
        set_ctrl(1'b0, 1'b0, 4'hF, fc);
        start_i = 1'b1;
        @(posedge clock);
        #1;
        start_i = 1'b0;
        repeat (4) @(negedge clock);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy_o); end
        resetn = 1'b0;
        @(negedge clock);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_busy_after: got %b want 0", busy_o); end
        checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL mid_wr_en_after: got %b want 0", wr_en_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL mid_done_after: got %b want 0", done_o); end
        resetn = 1'b1;
        bad_cnt = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clock);
            if (done_o || wr_en_o || busy_o) bad_cnt++;
        end
        checks++; if (bad_cnt !== 0) begin errors++; $display("FAIL mid_quiet: got %0d active cycles want 0", bad_cnt); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int e = 0; e < NUM_ENT; e++) set_entry(e, 0, 0);
        test_reset();
        test_basic();
        test_wrap();
        test_field();
        test_mask_err();
        test_masked_invalid();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
